// File: rtl/hw_timer_sequencer.sv
// hw_timer_sequencer: Avalon-MM master that turns local commands and timer irqs
// into interval-timer register access sequences.
module hw_timer_sequencer #(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [31:0]            cmd_period,
   input  logic                   cmd_continuous,
   input  logic                   cmd_irq_en,
   output logic                   rsp_valid,
   output logic [31:0]            rsp_data,
   output logic [2:0]             avm_address,
   output logic                   avm_chipselect,
   output logic                   avm_write_n,
   output logic                   avm_read,
   output logic [15:0]            avm_writedata,
   input  logic [15:0]            avm_readdata,
   input  logic                   timer_irq,
   output logic                   timeout_pulse,
   output logic [COUNT_WIDTH-1:0] timeout_count,
   output logic                   busy
);
   typedef enum logic [3:0] {
      IDLE, WR_PL, WR_PH, GAP, WR_CTL, WR_STOP, SNAP_WR, RD_SL, RD_SH, CAP_SH,
      RD_ST, CAP_ST, IRQ_RD, IRQ_CAP, IRQ_CLR
   } state_t;
   state_t state_q, state_d;
   logic [15:0] period_h_q, snap_l_q, wd_q, wd_d;
   logic [2:0] addr_q, addr_d;
   logic cs_q, cs_d, wn_q, wn_d, rd_q, rd_d, cont_q, ien_q, pulse_q, accept, to_hit;
   logic [COUNT_WIDTH-1:0] count_q;
   assign cmd_ready = state_q == IDLE && !timer_irq && !reset;
   assign accept = cmd_valid && cmd_ready;
   assign to_hit = state_q == IRQ_CAP && avm_readdata[0];
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = timer_irq ? IRQ_RD : !cmd_valid ? IDLE : cmd_op == 2'd0 ? WR_PL :
                            cmd_op == 2'd1 ? WR_STOP : cmd_op == 2'd2 ? SNAP_WR : RD_ST;
         WR_PL:   state_d = WR_PH;
         WR_PH:   state_d = GAP;
         GAP:     state_d = WR_CTL;
         SNAP_WR: state_d = RD_SL;
         RD_SL:   state_d = RD_SH;
         RD_SH:   state_d = CAP_SH;
         RD_ST:   state_d = CAP_ST;
         IRQ_RD:  state_d = IRQ_CAP;
         IRQ_CAP: state_d = IRQ_CLR;
         default: state_d = IDLE;
      endcase
   end
   // Bus strobes are decoded from the next state so they are registered alongside it;
   // the low period half comes straight from the command port on the accepting edge.
   always_comb begin
      cs_d = 1'b1;
      wn_d = 1'b1;
      rd_d = 1'b0;
      addr_d = 3'd0;
      wd_d = 16'd0;
      case (state_d)
         WR_PL:   begin wn_d = 1'b0; addr_d = 3'd2; wd_d = cmd_period[15:0]; end
         WR_PH:   begin wn_d = 1'b0; addr_d = 3'd3; wd_d = period_h_q; end
         WR_CTL:  begin wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'b0, 2'b01, cont_q, ien_q}; end
         WR_STOP: begin wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'b0, 2'b10, cont_q, ien_q}; end
         SNAP_WR: begin wn_d = 1'b0; addr_d = 3'd4; end
         IRQ_CLR: wn_d = 1'b0;
         RD_SL:   begin rd_d = 1'b1; addr_d = 3'd4; end
         RD_SH:   begin rd_d = 1'b1; addr_d = 3'd5; end
         RD_ST, IRQ_RD: rd_d = 1'b1;
         default: cs_d = 1'b0;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cs_q <= 1'b0;
         wn_q <= 1'b1;
         rd_q <= 1'b0;
         addr_q <= 3'd0;
         wd_q <= 16'd0;
         period_h_q <= 16'd0;
         snap_l_q <= 16'd0;
         cont_q <= 1'b0;
         ien_q <= 1'b0;
         pulse_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cs_q <= cs_d;
         wn_q <= wn_d;
         rd_q <= rd_d;
         addr_q <= addr_d;
         wd_q <= wd_d;
         pulse_q <= to_hit;
         if (to_hit) count_q <= count_q + COUNT_WIDTH'(1);
         if (state_q == RD_SH) snap_l_q <= avm_readdata;
         if (accept) period_h_q <= cmd_period[31:16];
         if (accept && cmd_op == 2'd0) {cont_q, ien_q} <= {cmd_continuous, cmd_irq_en};
      end
   end
   assign avm_chipselect = cs_q;
   assign avm_write_n = wn_q;
   assign avm_read = rd_q;
   assign avm_address = addr_q;
   assign avm_writedata = wd_q;
   assign busy = state_q != IDLE;
   assign rsp_valid = state_q == CAP_SH || state_q == CAP_ST;
   assign rsp_data = state_q == CAP_SH ? {avm_readdata, snap_l_q} :
                     state_q == CAP_ST ? {30'b0, avm_readdata[1:0]} : 32'd0;
   assign timeout_pulse = pulse_q;
   assign timeout_count = count_q;
endmodule

// File: tb/tb_hw_timer_sequencer.sv
// tb_hw_timer_sequencer: directed bench with a behavioural timer slave; the count
// width is shrunk to 4 so the wrap case is reachable in a short run.
module tb_hw_timer_sequencer;
   logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_continuous = 1'b0, cmd_irq_en = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [31:0] cmd_period = 32'd0;
   logic cmd_ready, rsp_valid, avm_chipselect, avm_write_n, avm_read, timeout_pulse, busy, timer_irq;
   logic [31:0] rsp_data;
   logic [2:0] avm_address;
   logic [15:0] avm_writedata, avm_readdata;
   logic [3:0] timeout_count;
   logic st_to = 1'b0, tb_run = 1'b0, tb_set_to = 1'b0, spur = 1'b0;
   logic [15:0] snap_src_l = 16'd0, snap_src_h = 16'd0, snap_l = 16'd0, snap_h = 16'd0;
   logic [25:0] obs;
   int checks = 0, errors = 0;
   localparam logic [21:0] IB = 22'h100000;

   hw_timer_sequencer #(.COUNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .avm_address(avm_address),
      .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n), .avm_read(avm_read),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .timer_irq(timer_irq),
      .timeout_pulse(timeout_pulse), .timeout_count(timeout_count), .busy(busy)
   );

   always #5 clk = ~clk;
   assign timer_irq = st_to | spur;
   assign obs = {avm_chipselect, avm_write_n, avm_read, avm_address, avm_writedata,
                 busy, cmd_ready, rsp_valid, timeout_pulse};

   // Slave model: clear of TO wins over a coincident timeout; readdata has one cycle latency.
   always @(posedge clk) begin
      if (tb_set_to) st_to <= 1'b1;
      if (avm_chipselect && !avm_write_n && avm_address == 3'd0) st_to <= 1'b0;
      if (avm_chipselect && !avm_write_n && avm_address[2]) begin
         snap_l <= snap_src_l;
         snap_h <= snap_src_h;
      end
      if (avm_chipselect && avm_read)
         avm_readdata <= avm_address == 3'd0 ? {14'b0, tb_run, st_to} :
                         avm_address == 3'd4 ? snap_l : avm_address == 3'd5 ? snap_h : 16'h0;
   end

   function automatic logic [21:0] wr(logic [2:0] a, logic [15:0] d);
      return {3'b100, a, d};
   endfunction
   function automatic logic [21:0] rd(logic [2:0] a);
      return {3'b111, a, 16'h0};
   endfunction
   function automatic logic [25:0] ex(logic [21:0] b, logic [3:0] f);
      return {b, f};
   endfunction
   function automatic logic [25:0] msk(logic [25:0] x);
      return !x[25] ? {3'h7, 19'h0, 4'hF} : x[23] ? {6'h3F, 16'h0, 4'hF} : '1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cmd_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== ex(IB, 4'b0000)) begin
         errors++;
         $display("FAIL reset outputs obs=%h exp=%h", obs, ex(IB, 4'b0000));
      end
      checks++;
      if (rsp_data !== 32'd0 || timeout_count !== 4'd0) begin
         errors++;
         $display("FAIL reset data rsp_data=%h count=%h exp 0/0", rsp_data, timeout_count);
      end
      cmd_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_start();
      logic [25:0] x [6];
      x = '{ex(IB, 4'b0100), ex(wr(3'd2, 16'h0005), 4'b1000), ex(wr(3'd3, 16'h0001), 4'b1000),
            ex(IB, 4'b1000), ex(wr(3'd1, 16'h0007), 4'b1000), ex(IB, 4'b0100)};
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = 32'h0001_0005; cmd_continuous = 1'b1; cmd_irq_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ((obs & msk(x[i])) !== (x[i] & msk(x[i]))) begin
            errors++;
            $display("FAIL start c%0d obs=%h exp=%h", i, obs, x[i]);
         end
         tick();
         cmd_valid = 1'b0; cmd_period = 32'hFFFF_FFFF; cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
      end
   endtask

   task automatic test_status();
      logic [25:0] x [4];
      x = '{ex(IB, 4'b0100), ex(rd(3'd0), 4'b1000), ex(IB, 4'b1010), ex(IB, 4'b0100)};
      tb_run = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ((obs & msk(x[i])) !== (x[i] & msk(x[i]))) begin
            errors++;
            $display("FAIL status c%0d obs=%h exp=%h", i, obs, x[i]);
         end
         if (i == 2) begin
            checks++;
            if (rsp_data !== 32'h0000_0002) begin
               errors++;
               $display("FAIL status data got=%h exp=00000002", rsp_data);
            end
         end
         tick();
         cmd_valid = 1'b0; cmd_op = 2'd0;
      end
   endtask

   task automatic test_snap();
      logic [25:0] x [6];
      x = '{ex(IB, 4'b0100), ex(wr(3'd4, 16'h0000), 4'b1000), ex(rd(3'd4), 4'b1000),
            ex(rd(3'd5), 4'b1000), ex(IB, 4'b1010), ex(IB, 4'b0100)};
      snap_src_l = 16'h1234; snap_src_h = 16'h00AB;
      cmd_valid = 1'b1; cmd_op = 2'd2;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ((obs & msk(x[i])) !== (x[i] & msk(x[i]))) begin
            errors++;
            $display("FAIL snap c%0d obs=%h exp=%h", i, obs, x[i]);
         end
         if (i == 4) begin
            checks++;
            if (rsp_data !== 32'h00AB_1234) begin
               errors++;
               $display("FAIL snap data got=%h exp=00ab1234", rsp_data);
            end
         end
         tick();
         cmd_valid = 1'b0;
      end
   endtask

   task automatic test_irq(input string nm, input logic real_to, input logic [3:0] exp_cnt);
      logic [25:0] x [5];
      x = '{ex(IB, 4'b0000), ex(rd(3'd0), 4'b1000), ex(IB, 4'b1000),
            ex(wr(3'd0, 16'h0000), {3'b100, real_to}), ex(IB, 4'b0100)};
      if (real_to) begin
         tb_set_to = 1'b1;
         tick();
         tb_set_to = 1'b0;
      end else spur = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ((obs & msk(x[i])) !== (x[i] & msk(x[i]))) begin
            errors++;
            $display("FAIL %s c%0d obs=%h exp=%h", nm, i, obs, x[i]);
         end
         if (i == 3) begin
            checks++;
            if (timeout_count !== exp_cnt) begin
               errors++;
               $display("FAIL %s count got=%h exp=%h", nm, timeout_count, exp_cnt);
            end
         end
         tick();
         spur = 1'b0;
      end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 14; k++) begin
         tb_set_to = 1'b1;
         tick();
         tb_set_to = 1'b0;
         repeat (6) tick();
      end
      @(negedge clk);
      checks++;
      if (timeout_count !== 4'hF) begin
         errors++;
         $display("FAIL wrap precount got=%h exp=f", timeout_count);
      end
      tick();
      test_irq("wrap", 1'b1, 4'h0);
   endtask

   task automatic test_back_to_back();
      logic [25:0] x [7];
      x = '{ex(IB, 4'b0000), ex(rd(3'd0), 4'b1000), ex(IB, 4'b1000), ex(wr(3'd0, 16'h0000), 4'b1001),
            ex(IB, 4'b0100), ex(wr(3'd1, 16'h000B), 4'b1000), ex(IB, 4'b0100)};
      tb_set_to = 1'b1;
      tick();
      tb_set_to = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'd1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if ((obs & msk(x[i])) !== (x[i] & msk(x[i]))) begin
            errors++;
            $display("FAIL b2b c%0d obs=%h exp=%h", i, obs, x[i]);
         end
         tick();
         if (i == 4) cmd_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      logic [25:0] x [3];
      x = '{ex(IB, 4'b0100), ex(wr(3'd2, 16'h0003), 4'b1000), ex(wr(3'd3, 16'h0002), 4'b1000)};
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = 32'h0002_0003; cmd_continuous = 1'b0; cmd_irq_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ((obs & msk(x[i])) !== (x[i] & msk(x[i]))) begin
            errors++;
            $display("FAIL rmid c%0d obs=%h exp=%h", i, obs, x[i]);
         end
         if (i < 2) tick();
         cmd_valid = 1'b0;
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({avm_chipselect, avm_write_n, avm_read, busy} !== 4'b0100) begin
         errors++;
         $display("FAIL rmid async cs/wn/rd/busy=%b exp 0100", {avm_chipselect, avm_write_n, avm_read, busy});
      end
      @(negedge clk);
      checks++;
      if (obs !== ex(IB, 4'b0000)) begin
         errors++;
         $display("FAIL rmid held obs=%h exp=%h", obs, ex(IB, 4'b0000));
      end
      tick();
      reset = 1'b0;
      test_status();
      x = '{ex(IB, 4'b0100), ex(wr(3'd1, 16'h0008), 4'b1000), ex(IB, 4'b0100)};
      cmd_valid = 1'b1; cmd_op = 2'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ((obs & msk(x[i])) !== (x[i] & msk(x[i]))) begin
            errors++;
            $display("FAIL stop after reset c%0d obs=%h exp=%h", i, obs, x[i]);
         end
         tick();
         cmd_valid = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_status();
      test_snap();
      test_irq("irq", 1'b1, 4'h1);
      test_irq("spurious", 1'b0, 4'h1);
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
